// File: rtl/pattern_tx_101_if.sv
// pattern_tx_101_if: handshake and serial-stream bundle for pattern_tx_101.
//   start      : frame request from the controlling logic
//   data       : payload word, captured when start is accepted
//   dout       : serial bit stream toward the "101" detector
//   dout_valid : dout carries a preamble, payload or parity bit
//   busy       : a frame (including its gap) is in progress
//   done       : one-cycle pulse on return to IDLE after a frame
// master = controlling logic, slave = transmitter.
interface pattern_tx_101_if #(
  parameter int DATA_W = 8
) ();
  logic              start;
  logic [DATA_W-1:0] data;
  logic              dout;
  logic              dout_valid;
  logic              busy;
  logic              done;

  modport master (
    output start, data,
    input  dout, dout_valid, busy, done
  );

  modport slave (
    input  start, data,
    output dout, dout_valid, busy, done
  );
endinterface

// File: rtl/pattern_tx_101.sv
// pattern_tx_101: serial frame transmitter feeding the "101" sequence detector.
// On an accepted start it sends a fixed 1,0,1 preamble, then the payload
// MSB-first, then (optionally) an even-parity bit, then GAP_CYCLES zero bits.
// Parameters : DATA_W (1..32) payload width, GAP_CYCLES (0..255) idle bits.
// Ports      : clk, rst (synchronous, active-high), bus (pattern_tx_101_if.slave:
//              start/data in, dout/dout_valid/busy/done out, all registered).
// Macro      : PATTERN_TX_PARITY_EN adds the parity state after the payload.
module pattern_tx_101 #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 0
) (
  input logic             clk,
  input logic             rst,
  pattern_tx_101_if.slave bus
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_PAY  = 3'd2;
  localparam logic [2:0] ST_GAP  = 3'd4;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  // Where a frame goes once its last data-carrying bit has been sent.
  localparam logic [2:0] ST_AFTER_FRAME = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

`ifdef PATTERN_TX_PARITY_EN
  localparam logic [2:0] ST_PAR       = 3'd3;
  localparam logic [2:0] ST_AFTER_PAY = ST_PAR;

  // Even parity: XOR of all payload bits.
  function automatic logic even_parity_f(input logic [DATA_W-1:0] word);
    return ^word;
  endfunction

  logic par_r;
`else
  localparam logic [2:0] ST_AFTER_PAY = ST_AFTER_FRAME;
`endif

  logic [2:0]        state_r;
  logic [DATA_W-1:0] shift_r;
  logic [BIT_W-1:0]  bit_cnt_r;
  logic [1:0]        pre_cnt_r;
  logic [GAP_W-1:0]  gap_cnt_r;
  logic              dout_r;
  logic              dout_valid_r;
  logic              busy_r;
  logic              done_r;

  // Outputs are computed from the state held before the edge, so every output
  // lags the FSM by one cycle; done is the first IDLE cycle after busy.
  // Frame FSM, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      shift_r      <= '0;
      bit_cnt_r    <= '0;
      pre_cnt_r    <= 2'd0;
      gap_cnt_r    <= '0;
      dout_r       <= 1'b0;
      dout_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
`ifdef PATTERN_TX_PARITY_EN
      par_r        <= 1'b0;
`endif
    end else begin
      dout_r       <= 1'b0;
      dout_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // busy_r still high means the previous cycle was the last frame bit.
          done_r <= busy_r;
          if (bus.start) begin
            shift_r   <= bus.data;
            bit_cnt_r <= '0;
            pre_cnt_r <= 2'd0;
            gap_cnt_r <= '0;
`ifdef PATTERN_TX_PARITY_EN
            par_r     <= even_parity_f(bus.data);
`endif
            state_r   <= ST_PRE;
          end else begin
            state_r   <= ST_IDLE;
          end
        end
        ST_PRE: begin
          // Preamble 1,0,1 is simply the inverted LSB of the 0,1,2 counter.
          dout_r       <= ~pre_cnt_r[0];
          dout_valid_r <= 1'b1;
          busy_r       <= 1'b1;
          if (pre_cnt_r == 2'd2) begin
            state_r <= ST_PAY;
          end else begin
            pre_cnt_r <= pre_cnt_r + 2'd1;
          end
        end
        ST_PAY: begin
          dout_r       <= shift_r[DATA_W-1];
          dout_valid_r <= 1'b1;
          busy_r       <= 1'b1;
          shift_r      <= shift_r << 1;
          if (bit_cnt_r == BIT_LAST) begin
            state_r <= ST_AFTER_PAY;
          end else begin
            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
          end
        end
`ifdef PATTERN_TX_PARITY_EN
        ST_PAR: begin
          dout_r       <= par_r;
          dout_valid_r <= 1'b1;
          busy_r       <= 1'b1;
          state_r      <= ST_AFTER_FRAME;
        end
`endif
        ST_GAP: begin
          busy_r <= 1'b1;
          if (gap_cnt_r == GAP_LAST) begin
            state_r <= ST_IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r + GAP_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.dout       = dout_r;
  assign bus.dout_valid = dout_valid_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;

endmodule

// File: tb/tb_pattern_tx_101.sv
// Bench for pattern_tx_101: two instances (GAP_CYCLES=0 and 2) share stimulus.
// A queue-of-frames reference model predicts {dout,dout_valid,busy,done} for
// both every cycle; a directed table and a few hand sequences add fixed checks.
module tb_pattern_tx_101;
  localparam int DW = 8;
`ifdef PATTERN_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pattern_tx_101_if #(.DATA_W(DW)) bus0 ();
  pattern_tx_101_if #(.DATA_W(DW)) bus2 ();

  pattern_tx_101 #(.DATA_W(DW), .GAP_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  pattern_tx_101 #(.DATA_W(DW), .GAP_CYCLES(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [3:0] q0[$];
  logic [3:0] q2[$];
  logic [3:0] fq[$];

  typedef struct {
    logic       r;
    logic       s;
    logic [7:0] d;
    logic [3:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [3:0] obs0();
    return {bus0.dout, bus0.dout_valid, bus0.busy, bus0.done};
  endfunction

  function automatic logic [3:0] obs2();
    return {bus2.dout, bus2.dout_valid, bus2.busy, bus2.done};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Expected output after each edge E1..E(F+1) of one frame.
  task automatic build_frame(input logic [7:0] d, input int gap);
    fq.delete();
    fq.push_back(4'b1110);
    fq.push_back(4'b0110);
    fq.push_back(4'b1110);
    for (int k = DW - 1; k >= 0; k--) fq.push_back({d[k], 3'b110});
    if (P == 1) fq.push_back({^d, 3'b110});
    for (int g = 0; g < gap; g++) fq.push_back(4'b0010);
    fq.push_back(4'b0001);
  endtask

  // Transmitter is idle when nothing, or only the done cycle, is pending.
  task automatic model_edge(input int m, input logic r, input logic s,
                            input logic [7:0] d, output logic [3:0] e);
    int n;
    e = 4'b0000;
    if (r) begin
      if (m == 0) q0.delete();
      else        q2.delete();
    end else begin
      n = (m == 0) ? q0.size() : q2.size();
      if (n > 0) begin
        if (m == 0) e = q0.pop_front();
        else        e = q2.pop_front();
      end
      if (s && n <= 1) begin
        build_frame(d, (m == 0) ? 0 : 2);
        foreach (fq[i]) begin
          if (m == 0) q0.push_back(fq[i]);
          else        q2.push_back(fq[i]);
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic s, input logic [7:0] d);
    logic [3:0] e0;
    logic [3:0] e2;
    rst = r;
    bus0.start = s; bus0.data = d;
    bus2.start = s; bus2.data = d;
    model_edge(0, r, s, d, e0);
    model_edge(1, r, s, d, e2);
    @(posedge clk);
    #1;
    cyc++;
    check("model_gap0", {28'd0, obs0()}, {28'd0, e0});
    check("model_gap2", {28'd0, obs2()}, {28'd0, e2});
  endtask

  task automatic add(input logic r, input logic s, input logic [7:0] d, input logic [3:0] e);
    vec_t v;
    v.r = r; v.s = s; v.d = d; v.exp = e;
    tbl.push_back(v);
  endtask

  // Send one frame on dut0 and collect its valid bits and done position.
  task automatic capture(input logic [7:0] d, output int nval,
                         output logic [31:0] bits, output int done_at);
    nval = 0; bits = 32'd0; done_at = -1;
    step(1'b0, 1'b1, d);
    for (int c = 1; c <= 20; c++) begin
      step(1'b0, 1'b0, 8'h00);
      if (bus0.dout_valid) begin
        bits = {bits[30:0], bus0.dout};
        nval++;
      end
      if (bus0.done && done_at < 0) done_at = c;
    end
  endtask

  task automatic frame_checks(input string tag, input logic [7:0] d);
    int nval;
    int done_at;
    logic [31:0] bits;
    logic [31:0] want;
    capture(d, nval, bits, done_at);
    want = (P == 1) ? {20'd0, 3'b101, d, ^d} : {21'd0, 3'b101, d};
    check({tag, "_nvalid"}, nval, 11 + P);
    check({tag, "_bits"}, bits, want);
    check({tag, "_done_at"}, done_at, 12 + P);
  endtask

  initial begin
    int last0, last2, n0, n2;
    logic pv0, pv2;
    int nval, done_at;
    logic [31:0] bits;

    bus0.start = 1'b0; bus0.data = 8'h00;
    bus2.start = 1'b0; bus2.data = 8'h00;

    // Reset with start held, release, single 8'hA5 frame, ignored start at E5.
    for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 8'hA5, 4'b0000);
    add(1'b0, 1'b0, 8'h00, 4'b0000);
    add(1'b0, 1'b0, 8'h00, 4'b0000);
    add(1'b0, 1'b1, 8'hA5, 4'b0000);   // E0
    add(1'b0, 1'b0, 8'h00, 4'b1110);   // E1 preamble 1
    add(1'b0, 1'b0, 8'h00, 4'b0110);   // E2 preamble 0
    add(1'b0, 1'b0, 8'h00, 4'b1110);   // E3 preamble 1
    add(1'b0, 1'b0, 8'h00, 4'b1110);   // E4 bit7=1
    add(1'b0, 1'b1, 8'hFF, 4'b0110);   // E5 bit6=0, start ignored
    add(1'b0, 1'b0, 8'h00, 4'b1110);   // E6 bit5=1
    add(1'b0, 1'b0, 8'h00, 4'b0110);   // E7 bit4=0
    add(1'b0, 1'b0, 8'h00, 4'b0110);   // E8 bit3=0
    add(1'b0, 1'b0, 8'h00, 4'b1110);   // E9 bit2=1
    add(1'b0, 1'b0, 8'h00, 4'b0110);   // E10 bit1=0
    add(1'b0, 1'b0, 8'h00, 4'b1110);   // E11 bit0=1
`ifdef PATTERN_TX_PARITY_EN
    add(1'b0, 1'b0, 8'h00, 4'b0110);   // E12 parity of A5 = 0
`endif
    add(1'b0, 1'b0, 8'h00, 4'b0001);   // done
    add(1'b0, 1'b0, 8'h00, 4'b0000);
    add(1'b0, 1'b0, 8'h00, 4'b0000);
    add(1'b0, 1'b0, 8'h00, 4'b0000);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].s, tbl[i].d);
      check($sformatf("table_row%0d", i), {28'd0, obs0()}, {28'd0, tbl[i].exp});
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00);

    // Back-to-back: start held high, measure preamble-to-preamble period.
    last0 = -1; last2 = -1; n0 = 0; n2 = 0;
    pv0 = bus0.dout_valid; pv2 = bus2.dout_valid;
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b1, 8'($urandom));
      if (bus0.dout_valid && !pv0) begin
        if (last0 >= 0) check("period_gap0", cyc - last0, 12 + P);
        last0 = cyc; n0++;
      end
      if (bus2.dout_valid && !pv2) begin
        if (last2 >= 0) check("period_gap2", cyc - last2, 14 + P);
        last2 = cyc; n2++;
      end
      pv0 = bus0.dout_valid; pv2 = bus2.dout_valid;
    end
    check("b2b_frames_gap0", (n0 >= 4) ? 1 : 0, 1);
    check("b2b_frames_gap2", (n2 >= 3) ? 1 : 0, 1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 8'h00);

    // Reset in the middle of a frame: sampled at E7.
    step(1'b0, 1'b1, 8'h3C);
    for (int i = 1; i <= 6; i++) step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    check("midrst_dout", bus0.dout, 0);
    check("midrst_busy", bus0.busy, 0);
    check("midrst_busy_g2", bus2.busy, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'h00);
      check("midrst_no_done", {bus0.done, bus2.done}, 0);
    end
    frame_checks("after_rst", 8'hC3);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00);

    frame_checks("frame_07", 8'h07);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00);
    frame_checks("frame_03", 8'h03);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00);

`ifdef PATTERN_TX_PARITY_EN
    capture(8'h07, nval, bits, done_at);
    check("parity_07", bits[0], 1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00);
    capture(8'h03, nval, bits, done_at);
    check("parity_03", bits[0], 0);
    check("parity_03_done_at", done_at, 13);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00);
`endif

    // Randomized traffic with occasional resets, checked by the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
           8'($urandom));
    end
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
